// File: rtl/skinny_seq_pkg.sv
// Shared types and constants for the Skinny-64 masked S-box layer sequencer.
// The LFSR constants are only consumed when SBOX_SEQ_LFSR_EN is defined.
package skinny_seq_pkg;

    localparam int NIB     = 16;
    localparam int NIB_W   = 4;
    localparam int RND_W   = 64;
    localparam int STATE_W = 64;

    localparam logic [NIB_W-1:0] LAST_IDX = 4'(NIB - 1);

    // Fibonacci taps 64,63,61,60 expressed as bit positions 63,62,60,59.
    localparam logic [63:0] LFSR_SEED = 64'h0123_4567_89AB_CDEF;
    localparam logic [63:0] LFSR_TAPS = 64'hD800_0000_0000_0000;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FEED  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    function automatic logic lfsr_fb(input logic [63:0] s);
        return ^(s & LFSR_TAPS);
    endfunction

endpackage

// File: rtl/skinny_fresh_lfsr.sv
// 64-bit Fibonacci LFSR supplying S-box randomness; advances only when step is high.
// Instantiated by the sequencer only in SBOX_SEQ_LFSR_EN builds.
module skinny_fresh_lfsr
    import skinny_seq_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        step,
    output logic [63:0] rnd
);

    logic [63:0] lfsr_q;
    logic [63:0] lfsr_d;

    assign lfsr_d = {lfsr_q[62:0], lfsr_fb(lfsr_q)};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr_q <= LFSR_SEED;
        end else if (step) begin
            lfsr_q <= lfsr_d;
        end
    end

    assign rnd = lfsr_q;

endmodule

// File: rtl/skinny_sbox_layer_seq.sv
// Feeds a two-share 64-bit state one nibble per cycle into an external masked S-box
// and reassembles the results. Optional internal randomness: define SBOX_SEQ_LFSR_EN.
module skinny_sbox_layer_seq
    import skinny_seq_pkg::*;
#(
    parameter int SBOX_LAT = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [STATE_W-1:0] state_in_s0,
    input  logic [STATE_W-1:0] state_in_s1,
    input  logic [RND_W-1:0]   fresh_in,
    output logic               busy,
    output logic               done,
    output logic [STATE_W-1:0] state_out_s0,
    output logic [STATE_W-1:0] state_out_s1,
    output logic [NIB_W-1:0]   sbox_in_s0,
    output logic [NIB_W-1:0]   sbox_in_s1,
    output logic [RND_W-1:0]   sbox_fresh,
    input  logic [NIB_W-1:0]   sbox_out_s0,
    input  logic [NIB_W-1:0]   sbox_out_s1
);

    state_t             state_q;
    logic [NIB_W-1:0]   feed_cnt_q;
    logic [NIB_W-1:0]   feed_cnt_d;
    logic [STATE_W-1:0] shadow_s0_q;
    logic [STATE_W-1:0] shadow_s1_q;
    logic [STATE_W-1:0] out_s0_q;
    logic [STATE_W-1:0] out_s1_q;
    logic               busy_q;
    logic               done_q;

    logic [SBOX_LAT-1:0] vld_q;
    logic [NIB_W-1:0]    idx_q [SBOX_LAT];

    logic               feeding;
    logic               cap_vld;
    logic [NIB_W-1:0]   cap_idx;
    logic [5:0]         cap_pos;
    logic               last_cap;
    logic [RND_W-1:0]   rnd_word;

    assign feeding    = (state_q == FEED);
    assign feed_cnt_d = feed_cnt_q + 4'd1;
    assign cap_vld    = vld_q[SBOX_LAT-1];
    assign cap_idx    = idx_q[SBOX_LAT-1];
    assign cap_pos    = {cap_idx, 2'b00};
    assign last_cap   = cap_vld && (cap_idx == LAST_IDX);

`ifdef SBOX_SEQ_LFSR_EN
    logic unused_fresh;
    assign unused_fresh = ^fresh_in;

    skinny_fresh_lfsr u_lfsr (
        .clk   (clk),
        .rst_n (rst_n),
        .step  (feeding),
        .rnd   (rnd_word)
    );
`else
    assign rnd_word = fresh_in;
`endif

    // Shadow shares shift right each FEED cycle so the current nibble is always [3:0].
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            feed_cnt_q  <= '0;
            shadow_s0_q <= '0;
            shadow_s1_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        shadow_s0_q <= state_in_s0;
                        shadow_s1_q <= state_in_s1;
                        feed_cnt_q  <= '0;
                        busy_q      <= 1'b1;
                        state_q     <= FEED;
                    end
                end
                FEED: begin
                    shadow_s0_q <= {4'b0000, shadow_s0_q[STATE_W-1:4]};
                    shadow_s1_q <= {4'b0000, shadow_s1_q[STATE_W-1:4]};
                    feed_cnt_q  <= feed_cnt_d;
                    if (feed_cnt_q == LAST_IDX) begin
                        state_q <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (last_cap) begin
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Valid/index line mirrors the S-box pipeline so each result lands in its own nibble.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= '0;
            for (int i = 0; i < SBOX_LAT; i++) begin
                idx_q[i] <= '0;
            end
        end else begin
            vld_q[0] <= feeding;
            idx_q[0] <= feed_cnt_q;
            for (int i = 1; i < SBOX_LAT; i++) begin
                vld_q[i] <= vld_q[i-1];
                idx_q[i] <= idx_q[i-1];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_s0_q <= '0;
            out_s1_q <= '0;
        end else if (cap_vld) begin
            out_s0_q[cap_pos +: 4] <= sbox_out_s0;
            out_s1_q[cap_pos +: 4] <= sbox_out_s1;
        end
    end

    assign busy         = busy_q;
    assign done         = done_q;
    assign state_out_s0 = out_s0_q;
    assign state_out_s1 = out_s1_q;
    assign sbox_in_s0   = feeding ? shadow_s0_q[3:0] : '0;
    assign sbox_in_s1   = feeding ? shadow_s1_q[3:0] : '0;
    assign sbox_fresh   = feeding ? rnd_word : '0;

endmodule

// File: tb/tb_skinny_sbox_layer_seq.sv
// Bench for skinny_sbox_layer_seq with a behavioural two-share S-box (latency 2).
// Build with +define+SBOX_SEQ_LFSR_EN to exercise the internal randomness source.
module tb_skinny_sbox_layer_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [63:0] state_in_s0 = '0;
    logic [63:0] state_in_s1 = '0;
    logic [63:0] fresh_in = '0;
    logic        busy;
    logic        done;
    logic [63:0] state_out_s0;
    logic [63:0] state_out_s1;
    logic [3:0]  sbox_in_s0;
    logic [3:0]  sbox_in_s1;
    logic [63:0] sbox_fresh;
    logic [3:0]  sbox_out_s0;
    logic [3:0]  sbox_out_s1;

    int checks = 0;
    int errors = 0;

    localparam logic [63:0] VEC_IN  = 64'h0123_4567_89AB_CDEF;
    localparam logic [63:0] VEC_OUT = 64'hC690_1A2B_385D_4E7F;
    localparam logic [63:0] MASK_A  = 64'hA5A5_5A5A_F00F_3CC3;

    // Expected S-box input nibble pairs {s1,s0}, pushed at start and popped per FEED cycle.
    logic [7:0] exp_q[$];

    always #5 clk = ~clk;

    skinny_sbox_layer_seq #(.SBOX_LAT(2)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .state_in_s0  (state_in_s0),
        .state_in_s1  (state_in_s1),
        .fresh_in     (fresh_in),
        .busy         (busy),
        .done         (done),
        .state_out_s0 (state_out_s0),
        .state_out_s1 (state_out_s1),
        .sbox_in_s0   (sbox_in_s0),
        .sbox_in_s1   (sbox_in_s1),
        .sbox_fresh   (sbox_fresh),
        .sbox_out_s0  (sbox_out_s0),
        .sbox_out_s1  (sbox_out_s1)
    );

    function automatic logic [3:0] sbox_ref(input logic [3:0] x);
        case (x)
            4'h0: return 4'hC;  4'h1: return 4'h6;  4'h2: return 4'h9;  4'h3: return 4'h0;
            4'h4: return 4'h1;  4'h5: return 4'hA;  4'h6: return 4'h2;  4'h7: return 4'hB;
            4'h8: return 4'h3;  4'h9: return 4'h8;  4'hA: return 4'h5;  4'hB: return 4'hD;
            4'hC: return 4'h4;  4'hD: return 4'hE;  4'hE: return 4'h7;  default: return 4'hF;
        endcase
    endfunction

    function automatic logic [63:0] sub_ref(input logic [63:0] v);
        logic [63:0] r;
        for (int i = 0; i < 16; i++) r[4*i +: 4] = sbox_ref(v[4*i +: 4]);
        return r;
    endfunction

    // Two-stage masked S-box stand-in; output share 1 is refreshed from the randomness word.
    logic [3:0] p0_s0 = '0, p0_s1 = '0, p1_s0 = '0, p1_s1 = '0;
    always @(posedge clk) begin
        p0_s1 <= sbox_in_s1 ^ sbox_fresh[3:0];
        p0_s0 <= sbox_ref(sbox_in_s0 ^ sbox_in_s1) ^ sbox_in_s1 ^ sbox_fresh[3:0];
        p1_s0 <= p0_s0;
        p1_s1 <= p0_s1;
    end
    assign sbox_out_s0 = p1_s0;
    assign sbox_out_s1 = p1_s1;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic next_fresh();
`ifdef SBOX_SEQ_LFSR_EN
        fresh_in = '0;
`else
        fresh_in = {$urandom, $urandom};
`endif
    endtask

    // One complete run from IDLE: checks the feed stream, gating, busy and done timing.
    task automatic do_run(input logic [63:0] s0, input logic [63:0] s1,
                          output int done_cyc, output logic [63:0] o0, output logic [63:0] o1);
        logic [63:0] words[$];
        logic [7:0]  e;
        logic        bad;
        @(negedge clk);
        state_in_s0 = s0;
        state_in_s1 = s1;
        start = 1'b1;
        next_fresh();
        for (int i = 0; i < 16; i++) exp_q.push_back({s1[4*i +: 4], s0[4*i +: 4]});
        done_cyc = -1;
        o0 = '0;
        o1 = '0;
        for (int c = 1; c <= 40 && done_cyc < 0; c++) begin
            @(negedge clk);
            if (c <= 16) begin
                e = exp_q.pop_front();
                checks++;
                if ({sbox_in_s1, sbox_in_s0} !== e) begin
                    errors++;
                    $display("FAIL feed_nibble c=%0d: got %h need %h", c, {sbox_in_s1, sbox_in_s0}, e);
                end
`ifdef SBOX_SEQ_LFSR_EN
                words.push_back(sbox_fresh);
`else
                checks++;
                if (sbox_fresh !== fresh_in) begin
                    errors++;
                    $display("FAIL feed_fresh c=%0d: got %h need %h", c, sbox_fresh, fresh_in);
                end
`endif
            end else begin
                checks++;
                if (sbox_in_s0 !== 4'h0 || sbox_in_s1 !== 4'h0 || sbox_fresh !== 64'h0) begin
                    errors++;
                    $display("FAIL idle_gating c=%0d: got %h/%h/%h need 0", c, sbox_in_s0, sbox_in_s1, sbox_fresh);
                end
            end
            if (done === 1'b1) begin
                done_cyc = c;
                o0 = state_out_s0;
                o1 = state_out_s1;
                checks++;
                if (busy !== 1'b0) begin
                    errors++;
                    $display("FAIL busy_at_done: got %b need 0", busy);
                end
            end else begin
                checks++;
                if (busy !== 1'b1) begin
                    errors++;
                    $display("FAIL busy_in_run c=%0d: got %b need 1", c, busy);
                end
            end
            start = 1'b0;
            state_in_s0 = {$urandom, $urandom};
            state_in_s1 = {$urandom, $urandom};
            next_fresh();
        end
        if (done_cyc < 0) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: no done within 40 cycles");
        end
        exp_q.delete();
`ifdef SBOX_SEQ_LFSR_EN
        bad = (words.size() != 16);
        foreach (words[i]) begin
            if (words[i] == 64'h0) bad = 1'b1;
            for (int j = i + 1; j < words.size(); j++) if (words[i] == words[j]) bad = 1'b1;
        end
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL lfsr_words: got %0d words, distinct/nonzero violated", words.size());
        end
`else
        bad = 1'b0;
        words.delete();
`endif
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || state_out_s0 !== 64'h0 || state_out_s1 !== 64'h0) begin
            errors++;
            $display("FAIL reset_outputs: busy=%b done=%b out=%h/%h need 0", busy, done, state_out_s0, state_out_s1);
        end
        checks++;
        if (sbox_in_s0 !== 4'h0 || sbox_in_s1 !== 4'h0 || sbox_fresh !== 64'h0) begin
            errors++;
            $display("FAIL reset_sbox_if: got %h/%h/%h need 0", sbox_in_s0, sbox_in_s1, sbox_fresh);
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || sbox_fresh !== 64'h0) begin
            errors++;
            $display("FAIL idle_after_reset: busy=%b done=%b fresh=%h need 0", busy, done, sbox_fresh);
        end
    endtask

    task automatic test_unmasked();
        int dc;
        logic [63:0] o0, o1;
        do_run(VEC_IN, 64'h0, dc, o0, o1);
        checks++;
        if (dc != 19) begin
            errors++;
            $display("FAIL unmasked_latency: got %0d need 19", dc);
        end
        checks++;
        if ((o0 ^ o1) !== VEC_OUT) begin
            errors++;
            $display("FAIL unmasked_result: got %h need %h", o0 ^ o1, VEC_OUT);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (state_out_s0 !== o0 || state_out_s1 !== o1 || done !== 1'b0) begin
            errors++;
            $display("FAIL output_hold: got %h/%h done=%b need %h/%h", state_out_s0, state_out_s1, done, o0, o1);
        end
    endtask

    task automatic test_masked();
        int dc;
        logic [63:0] o0, o1;
        do_run(VEC_IN ^ MASK_A, MASK_A, dc, o0, o1);
        checks++;
        if (dc != 19 || (o0 ^ o1) !== VEC_OUT) begin
            errors++;
            $display("FAIL masked_result: cyc %0d val %h need 19 %h", dc, o0 ^ o1, VEC_OUT);
        end
    endtask

    task automatic test_back_to_back();
        int dones[$];
        logic [63:0] outs[$];
        logic [63:0] va, vb;
        va = {$urandom, $urandom};
        vb = {$urandom, $urandom};
        @(negedge clk);
        state_in_s0 = va;
        state_in_s1 = 64'h0;
        start = 1'b1;
        for (int c = 1; c <= 60 && dones.size() < 2; c++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                dones.push_back(c);
                outs.push_back(state_out_s0 ^ state_out_s1);
            end
            if (dones.size() == 2) start = 1'b0;
            state_in_s0 = vb;
            next_fresh();
        end
        start = 1'b0;
        checks++;
        if (dones.size() != 2) begin
            errors++;
            $display("FAIL b2b_done_count: got %0d need 2", dones.size());
        end else begin
            checks++;
            if (dones[0] != 19 || dones[1] != 39) begin
                errors++;
                $display("FAIL b2b_timing: got %0d,%0d need 19,39", dones[0], dones[1]);
            end
            checks++;
            if (outs[0] !== sub_ref(va) || outs[1] !== sub_ref(vb)) begin
                errors++;
                $display("FAIL b2b_results: got %h,%h need %h,%h", outs[0], outs[1], sub_ref(va), sub_ref(vb));
            end
        end
        for (int c = 0; c < 25; c++) begin
            @(negedge clk);
            checks++;
            if (done !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL b2b_extra_run c=%0d: done=%b busy=%b need 0", c, done, busy);
            end
        end
    endtask

    task automatic test_reset_mid_run();
        int dc;
        logic [63:0] o0, o1, v, m;
        @(negedge clk);
        state_in_s0 = {$urandom, $urandom};
        state_in_s1 = {$urandom, $urandom};
        start = 1'b1;
        repeat (8) begin
            @(negedge clk);
            start = 1'b0;
            next_fresh();
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || state_out_s0 !== 64'h0 || state_out_s1 !== 64'h0) begin
            errors++;
            $display("FAIL midrun_reset: busy=%b done=%b out=%h/%h need 0", busy, done, state_out_s0, state_out_s1);
        end
        checks++;
        if (sbox_in_s0 !== 4'h0 || sbox_in_s1 !== 4'h0 || sbox_fresh !== 64'h0) begin
            errors++;
            $display("FAIL midrun_sbox_if: got %h/%h/%h need 0", sbox_in_s0, sbox_in_s1, sbox_fresh);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 25; c++) begin
            @(negedge clk);
            checks++;
            if (done !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL midrun_no_done c=%0d: done=%b busy=%b need 0", c, done, busy);
            end
        end
        v = {$urandom, $urandom};
        m = {$urandom, $urandom};
        do_run(v ^ m, m, dc, o0, o1);
        checks++;
        if (dc != 19 || (o0 ^ o1) !== sub_ref(v)) begin
            errors++;
            $display("FAIL after_reset_run: cyc %0d val %h need 19 %h", dc, o0 ^ o1, sub_ref(v));
        end
    endtask

    task automatic test_all_ones();
        int dc;
        logic [63:0] o0, o1;
        do_run(64'hFFFF_FFFF_FFFF_FFFF, 64'h0, dc, o0, o1);
        checks++;
        if (dc != 19 || (o0 ^ o1) !== 64'hFFFF_FFFF_FFFF_FFFF) begin
            errors++;
            $display("FAIL all_ones: cyc %0d val %h need 19 ffffffffffffffff", dc, o0 ^ o1);
        end
    endtask

    task automatic test_random();
        int dc;
        logic [63:0] o0, o1, v, m;
        for (int k = 0; k < 5; k++) begin
            v = {$urandom, $urandom};
            m = {$urandom, $urandom};
            do_run(v ^ m, m, dc, o0, o1);
            checks++;
            if (dc != 19 || (o0 ^ o1) !== sub_ref(v)) begin
                errors++;
                $display("FAIL random_%0d: cyc %0d val %h need 19 %h", k, dc, o0 ^ o1, sub_ref(v));
            end
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end
    endtask

    initial begin
        test_reset();
        test_unmasked();
        test_masked();
        test_back_to_back();
        test_reset_mid_run();
        test_all_ones();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
